io_console: RTL and testbench
=============================

Name: io_console

Overview:
- Board-side counterpart to the processor's Input/Enter/Output interface. It is the initiator that drives `enter` into the processor, and the receiver that consumes the processor's 8-bit Output and Halt.
- Debounces the raw Enter and Scroll keys, synchronizes them, and converts an Enter press into an `enter` level held across exactly one processor clock tick.
- Captures each distinct processor output into a 4-entry history, scrollable on LEDG.
- Runs on the fast board clock; the processor clock rate is delivered as the `cpu_tick` strobe.

Parameters:
- DEBOUNCE_CYCLES, 8, consecutive identical synchronized samples required to accept a key level change.
- BLINK_CYCLES, 16, half-period in Clock cycles of the halt blink (used only with the optional feature).

Ports:
- Clock  input  1  board clock; all logic is on its rising edge.
- Reset  input  1  synchronous, active-low reset; Reset=0 at a rising Clock edge resets everything.
- key_enter_n  input  1  raw Enter pushbutton, active-low, asynchronous.
- key_scroll_n  input  1  raw Scroll pushbutton, active-low, asynchronous.
- cpu_tick  input  1  one-Clock-cycle strobe marking each processor clock edge.
- cpu_output  input  8  processor Output bus.
- cpu_halt  input  1  processor Halt.
- enter  output  1  Enter request to the processor.
- ledg  output  8  displayed history entry.
- hist_idx  output  2  current view offset; 0 = newest entry.
- halted  output  1  sticky halt indicator.

Behaviour:
- **Reset values:**
  - Outputs: enter=0, ledg=0, hist_idx=0, halted=0.
  - Internal state: history count=0, debounced key states=released (1), enter FSM=IDLE.
- **Synchronization:** each key passes through a 2-flop synchronizer before debounce.
- **Debounce:**
  - The counter resets whenever the synchronized sample differs from the debounced state.
  - The debounced state flips after DEBOUNCE_CYCLES consecutive differing samples.
  - A "press" is a debounced 1->0 transition and produces a one-cycle internal pulse.
  - Minimum press-to-pulse latency is DEBOUNCE_CYCLES+2 Clock cycles.
- **Enter FSM:**
  - IDLE: enter=0. On a press with halted=0, go to ARMED. A press while halted=1 is ignored (stay IDLE).
  - ARMED: enter=1. On the first Clock cycle with cpu_tick=1, go to RELEASE, so enter=0 from the next cycle. This guarantees enter is high across exactly one tick.
  - RELEASE: enter=0. When the debounced key is released (1), go to IDLE. Holding the key never generates a second request.
  - If cpu_halt is sampled on a tick while in ARMED, the FSM still completes that tick normally.
- **Output capture** (evaluated only on cycles with cpu_tick=1):
  - Capture when count==0 or cpu_output != newest stored entry.
  - A capture shifts the history (entry[3] is dropped, entry[0] := cpu_output) and increments count, saturating at 4.
  - A capture forces hist_idx=0.
- **Scroll:** a debounced Scroll press sets hist_idx := (hist_idx+1) mod count. With count=0, hist_idx stays 0.
- **Simultaneous events:** if a capture and a Scroll press occur in the same cycle, the capture wins and hist_idx=0.
- **ledg:** registered; equals entry[hist_idx], or 0 when count==0. It updates one cycle after a capture or scroll.
- **halted:**
  - Set on a cpu_tick cycle with cpu_halt=1.
  - Cleared only by Reset. While halted, captures continue.
- **Reset mid-operation:** Reset overrides all state in the same edge, including an ARMED enter and a partial debounce count.

Optional Feature:
- Macro: BLINK_ON_HALT_EN.
- Defined:
  - While halted=1, a free-running counter toggles a blink phase every BLINK_CYCLES Clock cycles.
  - ledg shows the selected entry in phase 0 and 8'h00 in phase 1.
  - The blink phase is reset to 0 when halted rises.
- Undefined: ledg is steady regardless of halted, and the blink counter is not instantiated.

Test Plan:
1. **Bounced Enter press:** key_enter_n toggles 3 times in 5 cycles, then is held 0 for 20 cycles; cpu_tick every 10 cycles.
   -> Exactly one enter assertion, rising DEBOUNCE_CYCLES+2=10 cycles after the stable low, held through exactly one tick, 0 afterwards until release and a new press.
2. **Capture with duplicate suppression:** cpu_output = 8'h05, 8'h05, 8'h2A, 8'hFF on successive ticks.
   -> count=3; ledg=8'hFF after the last tick, 8'h2A after 1 scroll, 8'h05 after 2 scrolls, 8'hFF after a 3rd scroll (wrap).
3. **History overflow:** 5 distinct outputs 1,2,3,4,5.
   -> count saturates at 4; scrolling shows 5,4,3,2, then 5 again; value 1 is never shown.
4. **Scroll/capture collision:** a scroll press pulse and a capture tick land in the same cycle with hist_idx=2.
   -> hist_idx=0 and ledg equals the newly captured value.
5. **Halt handling:** cpu_halt=1 sampled on a tick, then an Enter press.
   -> halted=1, enter stays 0. With BLINK_ON_HALT_EN defined, ledg alternates value/8'h00 every 16 cycles.
6. **Reset mid-request:** Reset=0 for one Clock edge while in ARMED with count=2.
   -> next cycle enter=0, ledg=0, hist_idx=0, halted=0; a later capture is stored as the first entry.

Source files
------------

// File: rtl/io_console.sv
// Board-side console for the processor Enter/Output/Halt interface: debounced keys,
// one-tick Enter handshake, 4-entry output history. Optional: BLINK_ON_HALT_EN.
module io_console_debounce #(
  parameter int DEBOUNCE_CYCLES = 8
) (
  input  logic Clock,
  input  logic Reset,
  input  logic raw_n,
  output logic level,
  output logic press
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          s1, s2;
  logic [CW-1:0] cnt;
  logic          flip;

  assign flip  = (s2 != level) && (cnt == CW'(DEBOUNCE_CYCLES - 1));
  // Press pulse coincides with the edge that commits the new low level.
  assign press = flip && !s2;

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      s1    <= 1'b1;
      s2    <= 1'b1;
      level <= 1'b1;
      cnt   <= '0;
    end else begin
      s1 <= raw_n;
      s2 <= s1;
      if (s2 == level) begin
        cnt <= '0;
      end else if (flip) begin
        level <= s2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

module io_console #(
  parameter int DEBOUNCE_CYCLES = 8,
  parameter int BLINK_CYCLES    = 16
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       key_enter_n,
  input  logic       key_scroll_n,
  input  logic       cpu_tick,
  input  logic [7:0] cpu_output,
  input  logic       cpu_halt,
  output logic       enter,
  output logic [7:0] ledg,
  output logic [1:0] hist_idx,
  output logic       halted
);
  localparam int NUM_KEYS = 2;

  typedef enum logic [1:0] {IDLE, ARMED, RELEASE} ent_t;

  logic [NUM_KEYS-1:0] key_raw, key_lvl, key_press;
  ent_t                state, state_nxt;
  logic [3:0][7:0]     hist, hist_nxt;
  logic [2:0]          count, count_nxt;
  logic [1:0]          idx_nxt;
  logic [2:0]          idx_inc;
  logic                capture;
  logic [7:0]          sel, ledg_d;

  assign key_raw = {key_scroll_n, key_enter_n};

  io_console_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db [NUM_KEYS-1:0] (
    .Clock (Clock),
    .Reset (Reset),
    .raw_n (key_raw),
    .level (key_lvl),
    .press (key_press)
  );

  always_ff @(posedge Clock) begin
    if (!Reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (key_press[0] && !halted) state_nxt = ARMED;
      ARMED:   if (cpu_tick)                state_nxt = RELEASE;
      RELEASE: if (key_lvl[0])              state_nxt = IDLE;
      default:                              state_nxt = IDLE;
    endcase
  end

  assign enter = (state == ARMED);

  // Capture has priority over scroll; ledg is computed from next-state values.
  always_comb begin
    hist_nxt  = hist;
    count_nxt = count;
    idx_nxt   = hist_idx;
    idx_inc   = {1'b0, hist_idx} + 3'd1;
    capture   = cpu_tick && ((count == 3'd0) || (cpu_output != hist[0]));
    if (capture) begin
      hist_nxt  = {hist[2:0], cpu_output};
      count_nxt = (count == 3'd4) ? 3'd4 : count + 3'd1;
      idx_nxt   = 2'd0;
    end else if (key_press[1]) begin
      idx_nxt = (idx_inc >= count) ? 2'd0 : idx_inc[1:0];
    end
    sel = (count_nxt == 3'd0) ? 8'h00 : hist_nxt[idx_nxt];
  end

`ifdef BLINK_ON_HALT_EN
  localparam int BW = $clog2(BLINK_CYCLES + 1);
  logic [BW-1:0] blink_cnt;
  logic          blink_ph;

  // Held at phase 0 until halted, so the blink always starts showing the value.
  always_ff @(posedge Clock) begin
    if (!Reset || !halted) begin
      blink_cnt <= '0;
      blink_ph  <= 1'b0;
    end else if (blink_cnt == BW'(BLINK_CYCLES - 1)) begin
      blink_cnt <= '0;
      blink_ph  <= ~blink_ph;
    end else begin
      blink_cnt <= blink_cnt + 1'b1;
    end
  end

  assign ledg_d = blink_ph ? 8'h00 : sel;
`else
  assign ledg_d = sel;
`endif

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      hist     <= '0;
      count    <= '0;
      hist_idx <= '0;
      ledg     <= '0;
      halted   <= 1'b0;
    end else begin
      hist     <= hist_nxt;
      count    <= count_nxt;
      hist_idx <= idx_nxt;
      ledg     <= ledg_d;
      if (cpu_tick && cpu_halt) halted <= 1'b1;
    end
  end
endmodule

// File: tb/tb_io_console.sv
// Self-checking bench for io_console: vector table, directed corner cases and a
// randomized run against a queue-based history model.
module tb_io_console;
  logic       Clock = 1'b0;
  logic       Reset, key_enter_n, key_scroll_n, cpu_tick, cpu_halt;
  logic [7:0] cpu_output;
  logic       enter, halted;
  logic [7:0] ledg;
  logic [1:0] hist_idx;

  int nvec = 0, nerr = 0, tcnt = 0;

  io_console dut (
    .Clock(Clock), .Reset(Reset), .key_enter_n(key_enter_n), .key_scroll_n(key_scroll_n),
    .cpu_tick(cpu_tick), .cpu_output(cpu_output), .cpu_halt(cpu_halt),
    .enter(enter), .ledg(ledg), .hist_idx(hist_idx), .halted(halted)
  );

  always #5 Clock = ~Clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, expected $finish");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge Clock);
    @(negedge Clock);
  endtask

  // Ticks every 10 cycles, as the processor clock would.
  task automatic step_t();
    cpu_tick = (tcnt % 10 == 0);
    tcnt++;
    step();
    cpu_tick = 1'b0;
  endtask

  task automatic do_reset();
    Reset = 1'b0; key_enter_n = 1'b1; key_scroll_n = 1'b1;
    cpu_tick = 1'b0; cpu_halt = 1'b0; cpu_output = 8'h00;
    step(); step();
    Reset = 1'b1;
  endtask

  task automatic tick(input logic [7:0] v);
    cpu_output = v; cpu_tick = 1'b1;
    step();
    cpu_tick = 1'b0;
  endtask

  task automatic scroll();
    key_scroll_n = 1'b0;
    repeat (14) step();
    key_scroll_n = 1'b1;
    repeat (14) step();
  endtask

  typedef struct {
    bit         is_scroll;
    logic [7:0] out;
    logic [7:0] eledg;
    logic [1:0] eidx;
  } vec_t;

  vec_t       tbl[15];
  logic [7:0] mq[$];
  int         midx;
  bit         mh;

  initial begin
    int rises, ticks_high, sc_start, zeros, nonz, wrong;
    bit prev, t, sc_ph, pulse, seen, cap, r_tick, r_halt;
    logic [7:0] r_out, eled;

    tbl[0]  = '{0, 8'h05, 8'h05, 2'd0};
    tbl[1]  = '{0, 8'h05, 8'h05, 2'd0};
    tbl[2]  = '{0, 8'h2A, 8'h2A, 2'd0};
    tbl[3]  = '{0, 8'hFF, 8'hFF, 2'd0};
    tbl[4]  = '{1, 8'h00, 8'h2A, 2'd1};
    tbl[5]  = '{1, 8'h00, 8'h05, 2'd2};
    tbl[6]  = '{1, 8'h00, 8'hFF, 2'd0};
    tbl[7]  = '{0, 8'h01, 8'h01, 2'd0};
    tbl[8]  = '{0, 8'h02, 8'h02, 2'd0};
    tbl[9]  = '{0, 8'h03, 8'h03, 2'd0};
    tbl[10] = '{0, 8'h04, 8'h04, 2'd0};
    tbl[11] = '{0, 8'h05, 8'h05, 2'd0};
    tbl[12] = '{1, 8'h00, 8'h04, 2'd1};
    tbl[13] = '{1, 8'h00, 8'h03, 2'd2};
    tbl[14] = '{1, 8'h00, 8'h02, 2'd3};

    // Reset state
    do_reset();
    chk("rst_enter", enter, 0);
    chk("rst_ledg", ledg, 0);
    chk("rst_idx", hist_idx, 0);
    chk("rst_halted", halted, 0);

    // Bounced Enter press
    key_enter_n = 1'b0; step_t(); step_t();
    key_enter_n = 1'b1; step_t(); step_t();
    key_enter_n = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      step_t();
      if (i >= 9) chk($sformatf("t1_enter_at_%0d", i), enter, (i == 10));
    end
    rises = enter ? 1 : 0; ticks_high = 0; prev = enter;
    for (int i = 0; i < 40; i++) begin
      t = (tcnt % 10 == 0);
      if (enter && t) ticks_high++;
      step_t();
      if (enter && !prev) rises++;
      prev = enter;
    end
    chk("t1_rises", rises, 1);
    chk("t1_ticks_high", ticks_high, 1);
    chk("t1_enter_held_low", enter, 0);
    key_enter_n = 1'b1;
    repeat (20) step_t();
    chk("t1_enter_after_rel", enter, 0);
    key_enter_n = 1'b0; seen = 0;
    for (int i = 0; i < 15 && !seen; i++) begin
      step_t();
      if (enter) seen = 1;
    end
    chk("t1_second_press", seen, 1);
    key_enter_n = 1'b1;
    repeat (20) step_t();

    // Capture, duplicate suppression, overflow and scroll wrap
    do_reset();
    for (int i = 0; i < 15; i++) begin
      if (tbl[i].is_scroll) scroll();
      else                  tick(tbl[i].out);
      chk($sformatf("tbl%0d_ledg", i), ledg, tbl[i].eledg);
      chk($sformatf("tbl%0d_idx", i), hist_idx, tbl[i].eidx);
    end
    scroll();
    chk("ovf_wrap_ledg", ledg, 8'h05);

    // Scroll pulse and capture in the same cycle with hist_idx=2
    scroll(); scroll();
    chk("coll_pre_idx", hist_idx, 2);
    key_scroll_n = 1'b0;
    repeat (9) step();
    tick(8'h77);
    chk("coll_idx", hist_idx, 0);
    chk("coll_ledg", ledg, 8'h77);
    step();
    chk("coll_idx_after", hist_idx, 0);
    key_scroll_n = 1'b1;
    repeat (14) step();

    // Randomized run against the history model
    do_reset();
    mq.delete(); midx = 0; mh = 0; sc_ph = 0; sc_start = 0;
    for (int i = 0; i < 600; i++) begin
      if (!sc_ph && ($urandom % 8 == 0)) begin sc_ph = 1; sc_start = i; end
      key_scroll_n = !(sc_ph && (i - sc_start < 14));
      pulse  = sc_ph && (i - sc_start == 9);
      r_tick = ($urandom % 3 == 0);
      r_out  = 8'h10 + 8'($urandom % 4);
`ifdef BLINK_ON_HALT_EN
      r_halt = 1'b0;
`else
      r_halt = ($urandom % 150 == 0);
`endif
      cpu_tick = r_tick; cpu_output = r_out; cpu_halt = r_halt;
      step();
      cpu_tick = 1'b0; cpu_halt = 1'b0;
      cap = r_tick && (mq.size() == 0 || r_out != mq[0]);
      if (cap) begin
        mq.push_front(r_out);
        if (mq.size() > 4) void'(mq.pop_back());
        midx = 0;
      end else if (pulse && mq.size() > 0) begin
        midx = (midx + 1) % mq.size();
      end
      if (r_tick && r_halt) mh = 1;
      eled = (mq.size() == 0) ? 8'h00 : mq[midx];
      chk($sformatf("rnd%0d_ledg", i), ledg, eled);
      chk($sformatf("rnd%0d_idx", i), hist_idx, midx);
      chk($sformatf("rnd%0d_halted", i), halted, mh);
      if (sc_ph && (i - sc_start >= 27)) sc_ph = 0;
    end

    // Halt then Enter press
    do_reset();
    cpu_halt = 1'b1; tick(8'h42); cpu_halt = 1'b0;
    chk("halt_set", halted, 1);
    chk("halt_ledg", ledg, 8'h42);
    key_enter_n = 1'b0; seen = 0; zeros = 0; nonz = 0; wrong = 0;
    repeat (60) begin
      step();
      if (enter) seen = 1;
      if (ledg == 8'h00) zeros++;
      else if (ledg == 8'h42) nonz++;
      else wrong++;
    end
    chk("halt_no_enter", seen, 0);
    chk("halt_ledg_values", wrong, 0);
`ifdef BLINK_ON_HALT_EN
    chk("halt_blink_zeros", zeros > 20, 1);
    chk("halt_blink_shown", nonz > 20, 1);
`else
    chk("halt_steady", zeros, 0);
`endif
    key_enter_n = 1'b1;
    repeat (14) step();
    chk("halt_sticky", halted, 1);

    // Reset while ARMED with two stored entries
    do_reset();
    tick(8'h11); tick(8'h22);
    key_enter_n = 1'b0; seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      step();
      if (enter) seen = 1;
    end
    chk("mid_armed", seen, 1);
    Reset = 1'b0; key_enter_n = 1'b1;
    step();
    Reset = 1'b1;
    chk("mid_enter", enter, 0);
    chk("mid_ledg", ledg, 0);
    chk("mid_idx", hist_idx, 0);
    chk("mid_halted", halted, 0);
    tick(8'h33);
    chk("mid_first_ledg", ledg, 8'h33);
    scroll();
    chk("mid_one_entry_idx", hist_idx, 0);
    chk("mid_one_entry_ledg", ledg, 8'h33);
    tick(8'h44);
    scroll();
    chk("mid_two_entry_ledg", ledg, 8'h33);
    chk("mid_two_entry_idx", hist_idx, 1);
    chk("mid_no_enter", enter, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
